ibex_csr_err_alert: RTL and testbench

Collects the `rd_error_o` shadow-mismatch flags of up to `NumCsrs` shadowed `ibex_csr_body` instances, records which CSRs have failed, and counts error events. It drives a four-phase req/ack alert handshake towards the core's fatal-alert path. It sits directly downstream of the CSR primitives inside the CSR file.

---
 rtl/ibex_csr_err_alert_pkg.sv | 10 +
 rtl/ibex_csr_err_alert.sv | 97 +++++++++
 tb/tb_ibex_csr_err_alert.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ibex_csr_err_alert_pkg.sv
// Shared types for the CSR shadow-error alert collector.
package ibex_csr_err_alert_pkg;

    typedef enum logic [1:0] {
        CSR_ALERT_IDLE,
        CSR_ALERT_REQ,
        CSR_ALERT_HOLD
    } csr_alert_state_e;

endpackage

// File: rtl/ibex_csr_err_alert.sv
// Collects shadowed-CSR mismatch flags, records causes, counts events and
// raises a four-phase req/ack alert towards the fatal-alert path.
module ibex_csr_err_alert
    import ibex_csr_err_alert_pkg::*;
#(
    parameter int unsigned NumCsrs  = 4,
    parameter int unsigned CntWidth = 8
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [NumCsrs-1:0]  csr_err_i,
    input  logic [NumCsrs-1:0]  err_mask_i,
    input  logic                clear_i,
    input  logic                alert_ack_i,
    output logic                alert_req_o,
    output logic [NumCsrs-1:0]  err_cause_o,
    output logic [CntWidth-1:0] err_cnt_o,
    output logic                fatal_o
);

    logic [NumCsrs-1:0]  err_q, err_prev_q, new_err, err_cause_q;
    logic [CntWidth-1:0] err_cnt_q, err_cnt_d;
    logic                any_new, fatal_q, pending_q, pending_d;
    logic                alert_req_q, alert_req_d;
    csr_alert_state_e    state_q, state_d;

    // A level held high is one event; only rising edges of the masked flags count.
    assign new_err = err_q & ~err_prev_q;
    assign any_new = |new_err;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (clear_i) begin
            err_cnt_d = CntWidth'(any_new);
        end else if (any_new && (err_cnt_q != {CntWidth{1'b1}})) begin
            err_cnt_d = err_cnt_q + CntWidth'(1);
        end
    end

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        unique case (state_q)
            CSR_ALERT_IDLE: begin
                if (any_new || pending_q) begin
                    state_d   = CSR_ALERT_REQ;
                    pending_d = 1'b0;
                end
            end
            CSR_ALERT_REQ: begin
                pending_d = pending_q | any_new;
                if (alert_ack_i) state_d = CSR_ALERT_HOLD;
            end
            CSR_ALERT_HOLD: begin
                pending_d = pending_q | any_new;
                if (!alert_ack_i) state_d = CSR_ALERT_IDLE;
            end
            default: state_d = CSR_ALERT_IDLE;
        endcase
        alert_req_d = (state_d == CSR_ALERT_REQ);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q       <= '0;
            err_prev_q  <= '0;
            err_cause_q <= '0;
            err_cnt_q   <= '0;
            fatal_q     <= 1'b0;
            pending_q   <= 1'b0;
            alert_req_q <= 1'b0;
            state_q     <= CSR_ALERT_IDLE;
        end else begin
            err_q       <= csr_err_i & ~err_mask_i;
            err_prev_q  <= err_q;
            err_cause_q <= clear_i ? new_err : (err_cause_q | new_err);
            err_cnt_q   <= err_cnt_d;
            fatal_q     <= fatal_q | any_new;
            pending_q   <= pending_d;
            alert_req_q <= alert_req_d;
            state_q     <= state_d;
        end
    end

    assign alert_req_o = alert_req_q;
    assign err_cause_o = err_cause_q;
    assign err_cnt_o   = err_cnt_q;
    assign fatal_o     = fatal_q;

    a_ctrl_known: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !$isunknown({alert_ack_i, clear_i}));
    a_fatal_sticky: assert property (@(posedge clk_i) disable iff (!rst_ni)
        fatal_q |=> fatal_q);
    a_cnt_no_wrap: assert property (@(posedge clk_i) disable iff (!rst_ni)
        ((err_cnt_q == {CntWidth{1'b1}}) && !clear_i) |=> (err_cnt_q == {CntWidth{1'b1}}));

endmodule

// File: tb/tb_ibex_csr_err_alert.sv
// Bench for ibex_csr_err_alert: directed scenarios plus randomized traffic
// checked against an event-level reference model.
module tb_ibex_csr_err_alert;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] csr_err = '0, err_mask = '0;
    logic       clear = 1'b0, ack = 1'b0;
    logic       alert_req, fatal, alert_req_s, fatal_s;
    logic [3:0] err_cause, err_cause_s;
    logic [7:0] err_cnt;
    logic [1:0] err_cnt_s;

    int n_cmp = 0;
    int n_fail = 0;

    // reference model state
    logic [3:0] m_in, m_prev, m_cause;
    int         m_cnt, m_phase;  // m_phase: 0 idle, 1 requesting, 2 waiting for ack drop
    bit         m_fatal, m_pending;

    always #5 clk = ~clk;

    ibex_csr_err_alert #(.NumCsrs(4), .CntWidth(8)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .csr_err_i(csr_err), .err_mask_i(err_mask),
        .clear_i(clear), .alert_ack_i(ack), .alert_req_o(alert_req),
        .err_cause_o(err_cause), .err_cnt_o(err_cnt), .fatal_o(fatal)
    );

    ibex_csr_err_alert #(.NumCsrs(4), .CntWidth(2)) u_dut_sat (
        .clk_i(clk), .rst_ni(rst_n), .csr_err_i(csr_err), .err_mask_i(err_mask),
        .clear_i(clear), .alert_ack_i(ack), .alert_req_o(alert_req_s),
        .err_cause_o(err_cause_s), .err_cnt_o(err_cnt_s), .fatal_o(fatal_s)
    );

    function automatic int sat(int v, int w);
        int mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    function automatic bit exp_req();
        return m_phase == 1;
    endfunction

    task automatic model_reset();
        m_in = '0; m_prev = '0; m_cause = '0;
        m_cnt = 0; m_phase = 0; m_fatal = 0; m_pending = 0;
    endtask

    // One clock: model consumes the inputs seen at this edge, outputs sampled 1ns later.
    task automatic step();
        logic [3:0] edges;
        @(posedge clk);
        edges = m_in & ~m_prev;
        if (clear) begin
            m_cause = edges;
            m_cnt   = (edges != 0) ? 1 : 0;
        end else begin
            m_cause = m_cause | edges;
            if (edges != 0) m_cnt++;
        end
        if (edges != 0) m_fatal = 1;
        if (m_phase == 0) begin
            if (edges != 0 || m_pending) begin m_phase = 1; m_pending = 0; end
        end else begin
            if (edges != 0) m_pending = 1;
            if (m_phase == 1 && ack) m_phase = 2;
            else if (m_phase == 2 && !ack) m_phase = 0;
        end
        m_prev = m_in;
        m_in   = csr_err & ~err_mask;
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; csr_err = '0; err_mask = '0; clear = 0; ack = 0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        if ({alert_req, err_cause, err_cnt, fatal} !== 14'd0) begin
            n_fail++; $display("FAIL reset_outputs: got %h want 0", {alert_req, err_cause, err_cnt, fatal});
        end
        n_cmp++;
        if ({alert_req_s, err_cause_s, err_cnt_s, fatal_s} !== 8'd0) begin
            n_fail++; $display("FAIL reset_outputs_sat: got %h want 0", {alert_req_s, err_cause_s, err_cnt_s, fatal_s});
        end
        n_cmp++;
        do_reset();
    endtask

    task automatic test_single_error();
        int alerts = 0;
        logic last = 0;
        do_reset();
        csr_err = 4'b0100;
        for (int c = 1; c <= 14; c++) begin
            if (c == 5) ack = 1;
            if (c == 6) ack = 0;
            if (c == 11) csr_err = '0;
            step();
            if (alert_req && !last) alerts++;
            last = alert_req;
            if (alert_req !== exp_req()) begin
                n_fail++; $display("FAIL single_req c%0d: got %b want %b", c, alert_req, exp_req());
            end
            n_cmp++;
            if ((c == 1 || c == 5) && alert_req !== 1'b0) begin
                n_fail++; $display("FAIL single_req_low c%0d: got %b want 0", c, alert_req);
            end
            if (c == 2 && alert_req !== 1'b1) begin
                n_fail++; $display("FAIL single_req_latency: got %b want 1", alert_req);
            end
            if (c == 1 || c == 2 || c == 5) n_cmp++;
        end
        if (alerts != 1) begin n_fail++; $display("FAIL single_alert_count: got %0d want 1", alerts); end
        n_cmp++;
        if (err_cause !== 4'b0100 || err_cnt !== 8'd1 || fatal !== 1'b1) begin
            n_fail++; $display("FAIL single_state: cause %b cnt %0d fatal %b want 0100 1 1", err_cause, err_cnt, fatal);
        end
        n_cmp++;
    endtask

    task automatic test_pending();
        do_reset();
        csr_err = 4'b0001;
        step(); step();
        if (alert_req !== 1'b1) begin n_fail++; $display("FAIL pend_first_req: got %b want 1", alert_req); end
        n_cmp++;
        csr_err = 4'b1001;
        step(); step();
        ack = 1; step();
        if (alert_req !== 1'b0) begin n_fail++; $display("FAIL pend_hold: got %b want 0", alert_req); end
        n_cmp++;
        ack = 0; step();
        if (alert_req !== 1'b0) begin n_fail++; $display("FAIL pend_idle_gap: got %b want 0", alert_req); end
        n_cmp++;
        step();
        if (alert_req !== 1'b1 || exp_req() !== 1'b1) begin
            n_fail++; $display("FAIL pend_second_req: got %b want 1 (model %b)", alert_req, exp_req());
        end
        n_cmp++;
        if (err_cnt !== 8'd2 || err_cause !== 4'b1001) begin
            n_fail++; $display("FAIL pend_state: cnt %0d cause %b want 2 1001", err_cnt, err_cause);
        end
        n_cmp++;
    endtask

    task automatic test_clear_collision();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            csr_err = 4'b0001; step();
            csr_err = 4'b0000; step();
        end
        step(); step();
        if (err_cnt !== 8'd5 || err_cause !== 4'b0001) begin
            n_fail++; $display("FAIL clr_pre: cnt %0d cause %b want 5 0001", err_cnt, err_cause);
        end
        n_cmp++;
        csr_err = 4'b0100; step();
        clear = 1; step();
        clear = 0;
        if (err_cause !== 4'b0100 || err_cnt !== 8'd1 || fatal !== 1'b1) begin
            n_fail++; $display("FAIL clr_collision: cause %b cnt %0d fatal %b want 0100 1 1", err_cause, err_cnt, fatal);
        end
        n_cmp++;
        if (err_cnt !== 8'(m_cnt) || err_cause !== m_cause) begin
            n_fail++; $display("FAIL clr_model: cnt %0d cause %b want %0d %b", err_cnt, err_cause, m_cnt, m_cause);
        end
        n_cmp++;
    endtask

    task automatic test_saturation();
        do_reset();
        for (int p = 0; p < 5; p++) begin
            csr_err = 4'b0010; step();
            csr_err = 4'b0000;
            for (int k = 0; k < 8 && !alert_req_s; k++) step();
            if (alert_req_s !== 1'b1) begin n_fail++; $display("FAIL sat_req_timeout p%0d: got %b want 1", p, alert_req_s); end
            n_cmp++;
            ack = 1;
            for (int k = 0; k < 8 && alert_req_s; k++) step();
            ack = 0; step(); step();
        end
        if (err_cnt_s !== 2'd3) begin n_fail++; $display("FAIL sat_cnt: got %0d want 3", err_cnt_s); end
        n_cmp++;
        if (err_cnt !== 8'd5) begin n_fail++; $display("FAIL sat_wide_cnt: got %0d want 5", err_cnt); end
        n_cmp++;
        repeat (3) step();
        if (err_cnt_s !== 2'd3) begin n_fail++; $display("FAIL sat_hold: got %0d want 3", err_cnt_s); end
        n_cmp++;
    endtask

    task automatic test_masking();
        do_reset();
        err_mask = 4'b0010; csr_err = 4'b0010;
        repeat (4) step();
        if (alert_req !== 1'b0 || err_cnt !== 8'd0 || err_cause !== 4'd0) begin
            n_fail++; $display("FAIL mask_quiet: req %b cnt %0d cause %b want 0 0 0", alert_req, err_cnt, err_cause);
        end
        n_cmp++;
        err_mask = 4'b0000;
        step(); step();
        if (alert_req !== 1'b1 || err_cnt !== 8'd1 || err_cause !== 4'b0010) begin
            n_fail++; $display("FAIL mask_unmask: req %b cnt %0d cause %b want 1 1 0010", alert_req, err_cnt, err_cause);
        end
        n_cmp++;
    endtask

    task automatic test_reset_mid_req();
        do_reset();
        csr_err = 4'b1000;
        step(); step();
        if (alert_req !== 1'b1) begin n_fail++; $display("FAIL rst_setup: got %b want 1", alert_req); end
        n_cmp++;
        #2 rst_n = 1'b0;
        #1;
        if ({alert_req, err_cause, err_cnt, fatal} !== 14'd0) begin
            n_fail++; $display("FAIL rst_async: got %h want 0", {alert_req, err_cause, err_cnt, fatal});
        end
        n_cmp++;
        csr_err = '0; ack = 1;
        model_reset();
        @(negedge clk) rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            if (alert_req !== 1'b0) begin n_fail++; $display("FAIL rst_idle c%0d: got %b want 0", c, alert_req); end
            n_cmp++;
        end
        ack = 0;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(7) == 0) csr_err[b] = ~csr_err[b];
            if ($urandom_range(31) == 0) err_mask = 4'($urandom_range(15));
            clear = ($urandom_range(15) == 0);
            if ($urandom_range(1) == 0) ack = exp_req() | (m_phase == 2 && $urandom_range(1) == 0);
            step();
            if (alert_req !== exp_req()) begin n_fail++; $display("FAIL rnd_req c%0d: got %b want %b", c, alert_req, exp_req()); end
            if (err_cause !== m_cause) begin n_fail++; $display("FAIL rnd_cause c%0d: got %b want %b", c, err_cause, m_cause); end
            if (err_cnt !== 8'(sat(m_cnt, 8))) begin n_fail++; $display("FAIL rnd_cnt c%0d: got %0d want %0d", c, err_cnt, sat(m_cnt, 8)); end
            if (err_cnt_s !== 2'(sat(m_cnt, 2))) begin n_fail++; $display("FAIL rnd_cnt_sat c%0d: got %0d want %0d", c, err_cnt_s, sat(m_cnt, 2)); end
            if (fatal !== m_fatal) begin n_fail++; $display("FAIL rnd_fatal c%0d: got %b want %b", c, fatal, m_fatal); end
            n_cmp += 5;
        end
        clear = 0; ack = 0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_error();
        test_pending();
        test_clear_collision();
        test_saturation();
        test_masking();
        test_reset_mid_req();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
